// File: rtl/mem_access_if.sv
// mem_access_if: pipeline and data-bus signals of the memory access stage
// Ports (signals):
//   in_*    EX-side record with valid/ready handshake
//   dreq_*  data-bus request, dresp_* data-bus completion
//   out_*   WB-side record with valid/ready handshake
//   out_misalign exists only when MEM_MISALIGN_CHECK_EN is defined
// Modports: slave = the stage itself, master = its surroundings
interface mem_access_if #(parameter int XLEN = 64, parameter int REGW = 5);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_result;
   logic [XLEN-1:0] in_wdata;
   logic            in_load;
   logic            in_store;
   logic [1:0]      in_size;
   logic            in_unsigned;
   logic [REGW-1:0] in_rd;
   logic            in_wen;
   logic            dreq_valid;
   logic            dreq_write;
   logic [XLEN-1:0] dreq_addr;
   logic [7:0]      dreq_strobe;
   logic [XLEN-1:0] dreq_wdata;
   logic            dresp_valid;
   logic [XLEN-1:0] dresp_rdata;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data;
   logic [REGW-1:0] out_rd;
   logic            out_wen;
`ifdef MEM_MISALIGN_CHECK_EN
   logic            out_misalign;
   modport slave (
      input  in_valid, in_result, in_wdata, in_load, in_store, in_size, in_unsigned, in_rd, in_wen,
      input  dresp_valid, dresp_rdata, out_ready,
      output in_ready, dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_wdata,
      output out_valid, out_data, out_rd, out_wen, out_misalign
   );
   modport master (
      output in_valid, in_result, in_wdata, in_load, in_store, in_size, in_unsigned, in_rd, in_wen,
      output dresp_valid, dresp_rdata, out_ready,
      input  in_ready, dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_wdata,
      input  out_valid, out_data, out_rd, out_wen, out_misalign
   );
`else
   modport slave (
      input  in_valid, in_result, in_wdata, in_load, in_store, in_size, in_unsigned, in_rd, in_wen,
      input  dresp_valid, dresp_rdata, out_ready,
      output in_ready, dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_wdata,
      output out_valid, out_data, out_rd, out_wen
   );
   modport master (
      output in_valid, in_result, in_wdata, in_load, in_store, in_size, in_unsigned, in_rd, in_wen,
      output dresp_valid, dresp_rdata, out_ready,
      input  in_ready, dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_wdata,
      input  out_valid, out_data, out_rd, out_wen
   );
`endif
endinterface

// File: rtl/mem_access.sv
// mem_access: memory stage issuing one bus transaction per load/store and producing a WB record
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    mem_access_if.slave (EX handshake, data bus, WB handshake)
// Optional feature: MEM_MISALIGN_CHECK_EN adds out_misalign and faults misaligned mem ops
module mem_access (
   input logic        clk,
   input logic        reset,
   mem_access_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSREQ, DONE} state_t;
   state_t      state, state_n;
   logic        load_r, uns_r, mem_op, mis, accept;
   logic [1:0]  size_r;
   logic [2:0]  off_r;
   logic [7:0]  mask;
   logic [63:0] shifted, ext;
   assign mem_op = bus.in_load | bus.in_store;
   assign accept = (state == IDLE) & bus.in_valid;
   assign mask = bus.in_size == 2'd0 ? 8'h01 : bus.in_size == 2'd1 ? 8'h03 : bus.in_size == 2'd2 ? 8'h0f : 8'hff;
`ifdef MEM_MISALIGN_CHECK_EN
   assign mis = mem_op & (bus.in_size == 2'd1 ? bus.in_result[0] :
                          bus.in_size == 2'd2 ? |bus.in_result[1:0] :
                          bus.in_size == 2'd3 ? |bus.in_result[2:0] : 1'b0);
`else
   assign mis = 1'b0;
`endif
   assign shifted = bus.dresp_rdata >> {off_r, 3'b000};
   assign ext = size_r == 2'd0 ? {{56{~uns_r & shifted[7]}}, shifted[7:0]} :
                size_r == 2'd1 ? {{48{~uns_r & shifted[15]}}, shifted[15:0]} :
                size_r == 2'd2 ? {{32{~uns_r & shifted[31]}}, shifted[31:0]} : shifted;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      bus.in_ready = state == IDLE;
      bus.dreq_valid = state == BUSREQ;
      bus.out_valid = state == DONE;
      case (state)
         IDLE:    state_n = bus.in_valid ? ((mem_op & ~mis) ? BUSREQ : DONE) : IDLE;
         BUSREQ:  state_n = bus.dresp_valid ? DONE : BUSREQ;
         DONE:    state_n = bus.out_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   // bus request fields are registered at accept so they hold steady through any stall
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bus.dreq_write <= 1'b0;
         bus.dreq_addr <= '0;
         bus.dreq_strobe <= '0;
         bus.dreq_wdata <= '0;
         bus.out_data <= '0;
         bus.out_rd <= '0;
         bus.out_wen <= 1'b0;
         load_r <= 1'b0;
         uns_r <= 1'b0;
         size_r <= '0;
         off_r <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
         bus.out_misalign <= 1'b0;
`endif
      end else if (accept) begin
         bus.dreq_write <= bus.in_store;
         bus.dreq_addr <= {bus.in_result[63:3], 3'b000};
         bus.dreq_strobe <= mask << bus.in_result[2:0];
         bus.dreq_wdata <= bus.in_wdata << {bus.in_result[2:0], 3'b000};
         bus.out_data <= bus.in_result;
         bus.out_rd <= bus.in_rd;
         bus.out_wen <= bus.in_wen & ~bus.in_store & ~mis;
         load_r <= bus.in_load;
         uns_r <= bus.in_unsigned;
         size_r <= bus.in_size;
         off_r <= bus.in_result[2:0];
`ifdef MEM_MISALIGN_CHECK_EN
         bus.out_misalign <= mis;
`endif
      end else if ((state == BUSREQ) & bus.dresp_valid & load_r) begin
         bus.out_data <= ext;
      end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and random load/store/pass-through checks against a byte-level model
module tb_mem_access;
   logic clk, reset;
   int   total = 0, bad = 0;
   mem_access_if bus ();
   mem_access dut (.clk(clk), .reset(reset), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask
   function automatic logic [63:0] exp_load(input logic [63:0] rdata, input int o, input int sz, input bit uns);
      int n;
      logic [63:0] v;
      n = 1 << sz;
      v = 0;
      for (int i = 0; i < n; i++)
         if (o + i < 8) v = v | (64'(rdata[8*(o+i) +: 8]) << (8*i));
      if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      return v;
   endfunction
   function automatic logic [7:0] exp_strobe(input int o, input int sz);
      logic [7:0] s;
      s = 0;
      for (int i = 0; i < 8; i++)
         if (i >= o && i < o + (1 << sz)) s[i] = 1'b1;
      return s;
   endfunction
   function automatic logic [63:0] exp_wdata(input logic [63:0] wd, input int o);
      logic [63:0] w;
      w = 0;
      for (int i = 0; i < 8; i++)
         if (i >= o) w[8*i +: 8] = wd[8*(i-o) +: 8];
      return w;
   endfunction
   task automatic do_op(input logic [63:0] res, input logic [63:0] wd, input bit ld, input bit st,
                        input int sz, input bit un, input logic [4:0] rd, input bit wen,
                        input int stall, input int bp, input logic [63:0] rdata);
      int o;
      bit mem, mis;
      logic [63:0] exp_d;
      o = int'(res[2:0]);
      mem = ld || st;
      mis = 0;
`ifdef MEM_MISALIGN_CHECK_EN
      mis = mem && (res % (64'd1 << sz)) != 0;
`endif
      exp_d = (ld && !mis) ? exp_load(rdata, o, sz, un) : res;
      @(negedge clk);
      chk("idle_in_ready", bus.in_ready, 1);
      bus.in_valid = 1; bus.in_result = res; bus.in_wdata = wd; bus.in_load = ld; bus.in_store = st;
      bus.in_size = 2'(sz); bus.in_unsigned = un; bus.in_rd = rd; bus.in_wen = wen;
      @(negedge clk);
      bus.in_valid = 0;
      if (mem && !mis)
         for (int c = 0; c <= stall; c++) begin
            chk("dreq_valid", bus.dreq_valid, 1);
            chk("busy_in_ready", bus.in_ready, 0);
            chk("busy_out_valid", bus.out_valid, 0);
            chk("dreq_write", bus.dreq_write, st);
            chk("dreq_addr", bus.dreq_addr, res & ~64'd7);
            if (st) begin
               chk("dreq_strobe", bus.dreq_strobe, exp_strobe(o, sz));
               chk("dreq_wdata", bus.dreq_wdata, exp_wdata(wd, o));
            end
            bus.dresp_rdata = (c == stall) ? rdata : {$urandom, $urandom};
            bus.dresp_valid = (c == stall);
            @(negedge clk);
            bus.dresp_valid = 0;
         end
      for (int c = 0; c <= bp; c++) begin
         chk("done_dreq_valid", bus.dreq_valid, 0);
         chk("out_valid", bus.out_valid, 1);
         chk("done_in_ready", bus.in_ready, 0);
         if (!st || mis) chk("out_data", bus.out_data, exp_d);
         chk("out_rd", bus.out_rd, rd);
         chk("out_wen", bus.out_wen, wen && !st && !mis);
`ifdef MEM_MISALIGN_CHECK_EN
         chk("out_misalign", bus.out_misalign, mis);
`endif
         if (c < bp) begin
            bus.in_valid = 1; bus.in_result = ~res; bus.in_load = 0; bus.in_store = 0;
            @(negedge clk);
         end
      end
      bus.out_ready = 1;
      @(negedge clk);
      bus.out_ready = 0;
      bus.in_valid = 0;
      chk("handoff_in_ready", bus.in_ready, 1);
      chk("handoff_out_valid", bus.out_valid, 0);
   endtask
   initial begin
      reset = 1;
      bus.in_valid = 0; bus.in_result = 0; bus.in_wdata = 0; bus.in_load = 0; bus.in_store = 0;
      bus.in_size = 0; bus.in_unsigned = 0; bus.in_rd = 0; bus.in_wen = 0;
      bus.dresp_valid = 0; bus.dresp_rdata = 0; bus.out_ready = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_dreq_valid", bus.dreq_valid, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_wen", bus.out_wen, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_rd", bus.out_rd, 0);
      chk("rst_dreq_addr", bus.dreq_addr, 0);
      chk("rst_dreq_strobe", bus.dreq_strobe, 0);
      chk("rst_dreq_wdata", bus.dreq_wdata, 0);
`ifdef MEM_MISALIGN_CHECK_EN
      chk("rst_out_misalign", bus.out_misalign, 0);
`endif
      reset = 0;
      do_op(64'h1234, 0, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0);
      do_op(64'h1003, 0, 1, 0, 0, 0, 5'd7, 1, 0, 0, 64'h00000000_80000000);
      do_op(64'h1003, 0, 1, 0, 0, 1, 5'd8, 1, 1, 0, 64'h00000000_80000000);
      do_op(64'h2006, 64'hABCD, 0, 1, 1, 0, 5'd9, 1, 0, 0, 0);
      do_op(64'h4008, 0, 1, 0, 3, 0, 5'd10, 1, 5, 0, 64'h0123_4567_89AB_CDEF);
      do_op(64'h5555, 0, 0, 0, 0, 0, 5'd11, 1, 0, 3, 0);
      do_op(64'h1002, 0, 1, 0, 2, 0, 5'd12, 1, 0, 0, 64'hFEDC_BA98_7654_3210);
      do_op(64'h1006, 0, 1, 0, 2, 0, 5'd13, 1, 2, 1, 64'h8899_AABB_CCDD_EEFF);
      do_op(64'h3005, 64'h1122_3344_5566_7788, 0, 1, 3, 0, 5'd14, 1, 1, 0, 0);
      // reset while a load waits on the bus; the late response must not revive it
      @(negedge clk);
      bus.in_valid = 1; bus.in_result = 64'h3000; bus.in_load = 1; bus.in_store = 0; bus.in_size = 3;
      @(negedge clk);
      bus.in_valid = 0;
      chk("pre_rst_dreq_valid", bus.dreq_valid, 1);
      #2 reset = 1;
      #1;
      chk("mid_rst_dreq_valid", bus.dreq_valid, 0);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_dreq_addr", bus.dreq_addr, 0);
      @(negedge clk);
      reset = 0;
      bus.dresp_valid = 1; bus.dresp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      bus.dresp_valid = 0;
      chk("late_resp_out_valid", bus.out_valid, 0);
      chk("late_resp_in_ready", bus.in_ready, 1);
      chk("late_resp_out_data", bus.out_data, 0);
      for (int k = 0; k < 40; k++) begin
         int kind, sz;
         logic [63:0] res;
         kind = $urandom_range(0, 2);
         sz = $urandom_range(0, 3);
         res = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) res = res & ~((64'd1 << sz) - 64'd1);
         do_op(res, {$urandom, $urandom}, kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               $urandom_range(0, 2), {$urandom, $urandom});
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
